// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: ALU op codes for memory accesses and
// small op-class helpers used by the stage and its alignment logic.
package mem_access_pkg;

  localparam logic [31:0] ZERO_WORD = '0;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_mem(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between the MEM stage and memory.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_align.sv
// Combinational byte-lane helpers for the MEM stage: store/lane alignment and
// load extraction with sign/zero extension (big-endian lanes, sel[3] = byte 0).
module store_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misalign
);
  always_comb begin
    sel      = '0;
    wdata    = '0;
    misalign = 1'b0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{rt[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{rt[15:0]}};
        misalign = addr_lo[0];
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel      = 4'b1111;
        wdata    = rt;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end
endmodule

module load_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr_lo)
      2'b00:   b = rdata[31:24];
      2'b01:   b = rdata[23:16];
      2'b10:   b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (aluop)
      EXE_LB_OP:  data = {{24{b[7]}}, b};
      EXE_LBU_OP: data = {24'd0, b};
      EXE_LH_OP:  data = {{16{h[15]}}, h};
      EXE_LHU_OP: data = {16'd0, h};
      default:    data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// OpenMips MEM stage: EX/MEM latch, req/ack data-bus access FSM with timeout,
// and the registered MEM/WB result.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ex_wd_i,
  input  logic         ex_wreg_i,
  input  logic [31:0]  ex_wdata_i,
  input  logic [7:0]   ex_aluop_i,
  input  logic [31:0]  ex_mem_addr_i,
  input  logic [31:0]  ex_store_i,
  input  logic         stall_i,
  input  logic         flush_i,
  mem_access_if.master dbus,
  output logic         stallreq_o,
  output logic [4:0]   wb_wd_o,
  output logic         wb_wreg_o,
  output logic [31:0]  wb_wdata_o,
  output logic         addr_err_o,
  output logic         bus_err_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int unsigned CW = $clog2(TIMEOUT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          flushed;
  logic          m_live, m_wreg, m_mis;
  logic [4:0]    m_wd;
  logic [31:0]   m_wdata;
  logic [7:0]    m_aluop;
  logic [1:0]    m_lo;
  logic          req_q, we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    sel_q;
  logic [3:0]    ex_sel;
  logic [31:0]   ex_bus_wdata, ld_data;
  logic          ex_mis, done, take, start;

  store_align u_store (
    .aluop(ex_aluop_i), .addr_lo(ex_mem_addr_i[1:0]), .rt(ex_store_i),
    .sel(ex_sel), .wdata(ex_bus_wdata), .misalign(ex_mis)
  );

  load_align u_load (
    .aluop(m_aluop), .addr_lo(m_lo), .rdata(dbus.rdata), .data(ld_data)
  );

  // The latch also reloads on the edge that completes an access, so a
  // back-to-back memory op can start straight from ACCESS.
  always_comb begin
    done  = (state == ACCESS) && (dbus.ack || cnt == CW'(TIMEOUT - 1));
    take  = !stall_i && (state == IDLE || done);
    start = take && !flush_i && is_mem(ex_aluop_i) && !ex_mis;
  end

  assign stallreq_o = (state == ACCESS) && !dbus.ack;
  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flushed    <= 1'b0;
      m_live     <= 1'b0;
      m_wd       <= '0;
      m_wreg     <= 1'b0;
      m_wdata    <= ZERO_WORD;
      m_aluop    <= EXE_NOP_OP;
      m_lo       <= '0;
      m_mis      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= ZERO_WORD;
      sel_q      <= '0;
      wdata_q    <= ZERO_WORD;
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= ZERO_WORD;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      // A held latch retires its instruction once, then stays dead until reloaded
      if (take) begin
        if (flush_i) begin
          m_live  <= 1'b0;
          m_wd    <= '0;
          m_wreg  <= 1'b0;
          m_wdata <= ZERO_WORD;
          m_aluop <= EXE_NOP_OP;
          m_lo    <= '0;
          m_mis   <= 1'b0;
        end else begin
          m_live  <= 1'b1;
          m_wd    <= ex_wd_i;
          m_wreg  <= ex_wreg_i;
          m_wdata <= ex_wdata_i;
          m_aluop <= ex_aluop_i;
          m_lo    <= ex_mem_addr_i[1:0];
          m_mis   <= ex_mis;
        end
      end else if (state == IDLE || done) begin
        m_live <= 1'b0;
      end

      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= ZERO_WORD;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (done) begin
        bus_err_o <= !dbus.ack;
        if (dbus.ack && is_load(m_aluop) && m_wreg && !(flushed || flush_i)) begin
          wb_wd_o    <= m_wd;
          wb_wreg_o  <= 1'b1;
          wb_wdata_o <= ld_data;
        end
      end else if (state == IDLE && m_live) begin
        if (m_mis) begin
          addr_err_o <= 1'b1;
        end else begin
          wb_wd_o    <= m_wd;
          wb_wreg_o  <= m_wreg;
          wb_wdata_o <= m_wdata;
        end
      end

      if (start) begin
        state   <= ACCESS;
        cnt     <= '0;
        flushed <= 1'b0;
        req_q   <= 1'b1;
        we_q    <= is_store(ex_aluop_i);
        addr_q  <= {ex_mem_addr_i[31:2], 2'b00};
        sel_q   <= ex_sel;
        wdata_q <= is_store(ex_aluop_i) ? ex_bus_wdata : ZERO_WORD;
      end else if (done) begin
        state   <= IDLE;
        cnt     <= '0;
        flushed <= 1'b0;
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= ZERO_WORD;
        sel_q   <= '0;
        wdata_q <= ZERO_WORD;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (flush_i) flushed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and random ops against a
// byte-lane reference model derived from the MEM-stage rules.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 16;
  localparam logic [7:0] ADDU_OP = 8'b0010_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store;
  logic        stall, flush;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        addr_err, bus_err;
  int          total = 0;
  int          bad = 0;

  logic [7:0] mem_ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                              EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  logic [7:0] alu_ops [4] = '{ADDU_OP, 8'b0010_0101, 8'b0010_0110, EXE_NOP_OP};

  mem_access_if dbus ();

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata),
    .ex_aluop_i(ex_aluop), .ex_mem_addr_i(ex_mem_addr), .ex_store_i(ex_store),
    .stall_i(stall), .flush_i(flush), .dbus(dbus),
    .stallreq_o(stallreq), .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata),
    .addr_err_o(addr_err), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, big-endian lane placement, extension
  function automatic int op_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] a);
    int sz, off, s;
    sz  = op_size(op);
    off = int'(a[1:0]);
    s   = ((1 << sz) - 1) << (4 - sz - off);
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz, off;
    logic [63:0] m;
    logic [31:0] v;
    sz  = op_size(op);
    off = int'(a[1:0]);
    m   = (64'd1 << (8 * sz)) - 64'd1;
    v   = (rd >> (8 * (4 - sz - off))) & m[31:0];
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8*sz-1]) v = v | ~m[31:0];
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] rt);
    int sz;
    logic [63:0] m, v;
    sz = op_size(op);
    m  = (64'd1 << (8 * sz)) - 64'd1;
    v  = '0;
    for (int i = 0; i < 4 / sz; i++) v = (v << (8 * sz)) | (64'(rt) & m);
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    ex_aluop = EXE_NOP_OP; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
    ex_mem_addr = '0; ex_store = '0;
  endtask

  task automatic do_alu(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
    ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_mem_addr = $urandom; ex_store = $urandom;
    tick();
    set_nop();
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL alu_stallreq got=%b exp=0", stallreq); end
    tick();
    total++; if (wb_wd !== wd) begin bad++; $display("FAIL alu_wd got=%h exp=%h", wb_wd, wd); end
    total++; if (wb_wreg !== wreg) begin bad++; $display("FAIL alu_wreg got=%b exp=%b", wb_wreg, wreg); end
    total++; if (wb_wdata !== wdata) begin bad++; $display("FAIL alu_wdata got=%h exp=%h", wb_wdata, wdata); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL alu_addr_err got=%b exp=0", addr_err); end
  endtask

  // Issue one memory op, emulate the bus slave (ack after wait_n cycles, none if
  // wait_n >= TO) and optionally pulse flush_i in access cycle flush_at.
  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int wait_n, input int flush_at);
    int sz, lastk;
    bit ld, st, mis, acked;
    logic [4:0] wd;
    sz = op_size(op);
    ld = (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP});
    st = !ld;
    mis = (int'(addr[1:0]) % sz) != 0;
    wd = 5'($urandom_range(1, 31));
    ex_aluop = op; ex_mem_addr = addr; ex_store = rt; ex_wd = wd; ex_wreg = ld;
    ex_wdata = $urandom;
    tick();
    set_nop();
    if (mis) begin
      total++; if (dbus.req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", dbus.req); end
      tick();
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL mis_addr_err got=%b exp=1", addr_err); end
      total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL mis_wreg got=%b exp=0", wb_wreg); end
      total++; if (dbus.req !== 1'b0) begin bad++; $display("FAIL mis_req2 got=%b exp=0", dbus.req); end
      tick();
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", addr_err); end
      return;
    end
    total++; if (dbus.req !== 1'b1) begin bad++; $display("FAIL mem_req got=%b exp=1", dbus.req); end
    total++; if (dbus.we !== st) begin bad++; $display("FAIL mem_we got=%b exp=%b", dbus.we, st); end
    total++; if (dbus.addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL mem_addr got=%h exp=%h", dbus.addr, {addr[31:2], 2'b00}); end
    total++; if (dbus.sel !== exp_sel(op, addr)) begin bad++; $display("FAIL mem_sel got=%b exp=%b", dbus.sel, exp_sel(op, addr)); end
    if (st) begin
      total++; if (dbus.wdata !== exp_wdata(op, rt)) begin bad++; $display("FAIL mem_wdata got=%h exp=%h", dbus.wdata, exp_wdata(op, rt)); end
    end
    acked = wait_n < TO;
    lastk = acked ? wait_n : TO - 1;
    for (int k = 0; k <= lastk; k++) begin
      if (k > 0) begin
        total++; if (dbus.req !== 1'b1 || dbus.sel !== exp_sel(op, addr)) begin bad++; $display("FAIL mem_hold k=%0d req=%b sel=%b exp req=1 sel=%b", k, dbus.req, dbus.sel, exp_sel(op, addr)); end
        total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL mem_wait_wreg k=%0d got=%b exp=0", k, wb_wreg); end
      end
      dbus.ack = (k == wait_n);
      dbus.rdata = (k == wait_n) ? rdata : $urandom;
      flush = (k == flush_at);
      #1;
      total++; if (stallreq !== (k != wait_n)) begin bad++; $display("FAIL mem_stallreq k=%0d got=%b exp=%b", k, stallreq, k != wait_n); end
      tick();
    end
    dbus.ack = 1'b0;
    flush = 1'b0;
    total++; if (dbus.req !== 1'b0) begin bad++; $display("FAIL mem_req_drop got=%b exp=0", dbus.req); end
    total++; if (bus_err !== !acked) begin bad++; $display("FAIL mem_bus_err got=%b exp=%b", bus_err, !acked); end
    if (ld && acked && flush_at < 0) begin
      total++; if (wb_wreg !== 1'b1 || wb_wd !== wd) begin bad++; $display("FAIL ld_wb wreg=%b wd=%h exp wreg=1 wd=%h", wb_wreg, wb_wd, wd); end
      total++; if (wb_wdata !== exp_load(op, addr, rdata)) begin bad++; $display("FAIL ld_data got=%h exp=%h", wb_wdata, exp_load(op, addr, rdata)); end
    end else begin
      total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL mem_nowrite got=%b exp=0", wb_wreg); end
    end
    tick();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL bus_err_pulse got=%b exp=0", bus_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h100; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = $urandom;
    dbus.ack = 1'b1; dbus.rdata = $urandom;
    tick(); tick();
    total++;
    if ({dbus.req, dbus.we, dbus.addr, dbus.sel, dbus.wdata, stallreq, wb_wd, wb_wreg,
         wb_wdata, addr_err, bus_err} !== '0) begin
      bad++; $display("FAIL reset req=%b we=%b addr=%h sel=%b wdata=%h stallreq=%b wb=%h/%b/%h errs=%b%b exp all 0",
        dbus.req, dbus.we, dbus.addr, dbus.sel, dbus.wdata, stallreq, wb_wd, wb_wreg, wb_wdata, addr_err, bus_err);
    end
    dbus.ack = 1'b0;
    set_nop();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nonmem();
    do_alu(ADDU_OP, 5'd5, 1'b1, 32'h0000_1234);
    tick();
    total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL alu_bubble got=%b exp=0", wb_wreg); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pwd;
    logic pwreg;
    logic [31:0] pdata;
    pwd = '0; pwreg = 1'b0; pdata = '0;
    for (int i = 0; i < 8; i++) begin
      ex_aluop = alu_ops[$urandom_range(0, 3)]; ex_wd = 5'($urandom);
      ex_wreg = 1'($urandom); ex_wdata = $urandom;
      tick();
      if (i > 0) begin
        total++; if ({wb_wd, wb_wreg, wb_wdata} !== {pwd, pwreg, pdata}) begin bad++; $display("FAIL b2b i=%0d got=%h/%b/%h exp=%h/%b/%h", i, wb_wd, wb_wreg, wb_wdata, pwd, pwreg, pdata); end
      end
      total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL b2b_stallreq got=%b exp=0", stallreq); end
      pwd = ex_wd; pwreg = ex_wreg; pdata = ex_wdata;
    end
    set_nop();
    tick();
    total++; if ({wb_wd, wb_wreg, wb_wdata} !== {pwd, pwreg, pdata}) begin bad++; $display("FAIL b2b_last got=%h/%b/%h exp=%h/%b/%h", wb_wd, wb_wreg, wb_wdata, pwd, pwreg, pdata); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    ex_aluop = ADDU_OP; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = a;
    tick();
    stall = 1'b1;
    ex_wd = 5'd9; ex_wdata = b;
    tick();
    total++; if (wb_wreg !== 1'b1 || wb_wdata !== a) begin bad++; $display("FAIL stall_first wreg=%b data=%h exp 1/%h", wb_wreg, wb_wdata, a); end
    tick();
    total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b exp=0", wb_wreg); end
    tick();
    stall = 1'b0;
    tick();
    set_nop();
    tick();
    total++; if (wb_wd !== 5'd9 || wb_wreg !== 1'b1 || wb_wdata !== b) begin bad++; $display("FAIL stall_release got=%h/%b/%h exp=09/1/%h", wb_wd, wb_wreg, wb_wdata, b); end
    tick();
  endtask

  task automatic test_rst_mid();
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h500; ex_wd = 5'd4; ex_wreg = 1'b1;
    tick();
    set_nop();
    tick(); tick();
    total++; if (dbus.req !== 1'b1 || stallreq !== 1'b1) begin bad++; $display("FAIL rstmid_busy req=%b stallreq=%b exp 1/1", dbus.req, stallreq); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({dbus.req, stallreq, wb_wreg, bus_err} !== 4'b0) begin bad++; $display("FAIL rstmid_clear req=%b stallreq=%b wreg=%b bus_err=%b exp 0", dbus.req, stallreq, wb_wreg, bus_err); end
    dbus.ack = 1'b1; dbus.rdata = $urandom;
    tick();
    dbus.ack = 1'b0;
    total++; if ({dbus.req, wb_wreg, bus_err} !== 3'b0) begin bad++; $display("FAIL stray_ack req=%b wreg=%b bus_err=%b exp 0", dbus.req, wb_wreg, bus_err); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [31:0] addr;
    int sz, w, fl;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_alu(alu_ops[$urandom_range(0, 3)], 5'($urandom), 1'($urandom), $urandom);
      end else begin
        op = mem_ops[$urandom_range(0, 7)];
        sz = op_size(op);
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
        w = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 4));
        fl = -1;
        if ($urandom_range(0, 5) == 0) fl = int'($urandom_range(0, (w < TO) ? w : TO - 1));
        do_mem(op, addr, $urandom, $urandom, w, fl);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    dbus.ack = 1'b0; dbus.rdata = '0;
    set_nop();
    test_reset();
    test_nonmem();
    test_back_to_back();
    do_mem(EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h11F2_3344, 3, -1);
    do_mem(EXE_SH_OP, 32'h0000_0202, 32'hAAAA_BEEF, $urandom, 0, -1);
    do_mem(EXE_LW_OP, 32'h0000_0103, 32'h0, $urandom, 0, -1);
    do_mem(EXE_LW_OP, 32'h0000_0300, 32'h0, $urandom, 100, -1);
    do_alu(ADDU_OP, 5'd12, 1'b1, 32'hCAFE_0001);
    do_mem(EXE_LW_OP, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 3, 1);
    test_stall();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
